// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and the burst counter width rule for the
// eight-way round-robin channel arbiter.
package mux8_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Beat counter width: enough bits to count 0..burst_max-1, never zero bits.
    function automatic int cnt_width(input int burst_max);
        int w;
        w = $clog2(burst_max);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 single-bit multiplexer driven by a binary select.
module mux8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] d,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    assign y = d[s];

endmodule

// File: rtl/mux8_rr_arbiter_pick8.sv
// Combinational round-robin picker: first set request scanning from ptr
// upward with wrap 7 -> 0.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] offset;

    // Rotate requests so that position 0 is the current highest priority.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req[ptr + SEL_W'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) offset = SEL_W'(k);
        end
    end

    assign found  = |req;
    assign idx    = ptr + offset;
    assign onehot = found ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter owning the select lines of an 8:1 single-bit
// channel, with a valid/ready handshake towards the consumer.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic             dout,
    output logic             busy
);

    localparam int CNT_W = cnt_width(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    state_t           state_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [SEL_W-1:0] pick_ptr;
    logic             mux_y;
    logic             xfer;
    logic             release_now;

    // While granted the picker only matters on release, where the releasing
    // requester must become lowest priority; while idle it uses the pointer.
    assign pick_ptr = (state_reg == GRANT) ? (sel_reg + 1'b1) : ptr_reg;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    mux8 u_mux (
        .d (din),
        .s (sel_reg),
        .y (mux_y)
    );

    assign busy        = (state_reg == GRANT);
    assign out_valid   = busy & req[sel_reg];
    assign dout        = mux_y & out_valid;
    assign xfer        = out_valid & out_ready;
    assign release_now = busy & (~req[sel_reg] | (xfer & (cnt_reg == CNT_LAST)));

    // Arbitration FSM: grant, burst counting, release and immediate re-arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg <= GRANT;
                        gnt_reg   <= pick_onehot;
                        sel_reg   <= pick_idx;
                        cnt_reg   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_reg <= sel_reg + 1'b1;
                        cnt_reg <= '0;
                        if (pick_found) begin
                            gnt_reg <= pick_onehot;
                            sel_reg <= pick_idx;
                        end else begin
                            gnt_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end else if (xfer) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt = gnt_reg;
    assign sel = sel_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with BURST_MAX = 4.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic       out_ready;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out_valid;
    logic       dout;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    mux8_rr_arbiter #(.BURST_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] one;
        int         seq [9];
        rst_n     = 1'b0;
        req       = 8'h00;
        din       = 8'h00;
        out_ready = 1'b0;
        one       = 8'h01;
        #1;
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_sel", {5'd0, sel}, 8'd0);
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_dout", {7'd0, dout}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Full contention from ptr=0: 0..7 then wrap to 0, 4 beats each.
        pat       = 8'hA5;
        din       = pat;
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int b = 0; b < 4; b++) begin
                tick();
                chk($sformatf("rr_gnt k%0d b%0d", k, b), gnt, one << (k % 8));
                chk($sformatf("rr_sel k%0d b%0d", k, b), {5'd0, sel}, 8'(k % 8));
                chk($sformatf("rr_valid k%0d b%0d", k, b), {7'd0, out_valid}, 8'd1);
                chk($sformatf("rr_dout k%0d b%0d", k, b), {7'd0, dout}, {7'd0, pat[k % 8]});
            end
            $display("grant %0d burst done at %0t", k % 8, $time);
        end

        // Reset during beat 2 of the grant to index 1.
        tick();
        chk("mid_gnt_b1", gnt, 8'h02);
        tick();
        chk("mid_gnt_b2", gnt, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 8'h00);
        chk("mid_rst_sel", {5'd0, sel}, 8'd0);
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_dout", {7'd0, dout}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_gnt", gnt, 8'h01);
        chk("post_rst_sel", {5'd0, sel}, 8'd0);
        req = 8'h00;
        tick();
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_gnt", gnt, 8'h00);
        $display("reset mid-burst sequence done at %0t", $time);

        // Single requester 3 with toggling data; burst expiry re-grants with no gap.
        req = 8'h08;
        din = 8'h08;
        tick();
        chk("single_gnt", gnt, 8'h08);
        chk("single_sel", {5'd0, sel}, 8'd3);
        for (int b = 0; b < 6; b++) begin
            din = (b % 2 == 1) ? 8'h00 : 8'h08;
            #1;
            chk($sformatf("single_dout b%0d", b), {7'd0, dout}, (b % 2 == 1) ? 8'd0 : 8'd1);
            chk($sformatf("single_gnt b%0d", b), gnt, 8'h08);
            chk($sformatf("single_valid b%0d", b), {7'd0, out_valid}, 8'd1);
            chk($sformatf("single_busy b%0d", b), {7'd0, busy}, 8'd1);
            tick();
        end
        req = 8'h00;
        #1;
        chk("single_drop_valid", {7'd0, out_valid}, 8'd0);
        tick();
        chk("single_rel_gnt", gnt, 8'h00);
        chk("single_rel_sel", {5'd0, sel}, 8'd3);
        chk("single_rel_busy", {7'd0, busy}, 8'd0);
        $display("single requester sequence done at %0t", $time);

        // Early withdrawal: ptr=4, req=60 grants 5; drop after 2 beats.
        req = 8'h60;
        tick();
        chk("wd_gnt5", gnt, 8'h20);
        tick();
        tick();
        chk("wd_gnt5_b2", gnt, 8'h20);
        req = 8'h40;
        #1;
        chk("wd_valid_drop", {7'd0, out_valid}, 8'd0);
        tick();
        chk("wd_gnt6", gnt, 8'h40);
        chk("wd_sel6", {5'd0, sel}, 8'd6);
        $display("early withdrawal sequence done at %0t", $time);

        // Stall: 2 beats of 6 done, hold out_ready low 10 cycles, then 2 more beats.
        tick();
        tick();
        req       = 8'hC0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("stall_gnt c%0d", c), gnt, 8'h40);
            chk($sformatf("stall_sel c%0d", c), {5'd0, sel}, 8'd6);
            chk($sformatf("stall_valid c%0d", c), {7'd0, out_valid}, 8'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_gnt_last", gnt, 8'h40);
        tick();
        chk("resume_gnt_next", gnt, 8'h80);
        $display("stall sequence done at %0t", $time);

        // Pointer fairness: 7 (already granted), then 0, then 7 again.
        req = 8'h81;
        seq = '{7, 7, 7, 7, 0, 0, 0, 0, 7};
        chk("fair_s0", {5'd0, sel}, 8'd7);
        for (int s = 1; s < 9; s++) begin
            tick();
            chk($sformatf("fair_sel s%0d", s), {5'd0, sel}, 8'(seq[s]));
            chk($sformatf("fair_gnt s%0d", s), gnt, one << seq[s]);
        end
        req = 8'h00;
        tick();
        chk("end_busy", {7'd0, busy}, 8'd0);
        $display("fairness sequence done at %0t", $time);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
